// File: rtl/instrumented_adder_sweep_if.sv
// Control / result-read bus of the instrumented adder sweep sequencer.
// master = CPU side (start, range, read address); slave = sequencer.
interface instrumented_adder_sweep_if #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 32,
    parameter int TIME_W = 32
);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic              start;
    logic              abort;
    logic [TIME_W-1:0] integration_time;
    logic [AW-1:0]     first_bit;
    logic [AW-1:0]     last_bit;
    logic              busy;
    logic              done;
    logic [AW-1:0]     rd_addr;
    logic [CNT_W-1:0]  rd_data;
    logic [WIDTH-1:0]  ovf;

    modport master (
        output start, abort, integration_time, first_bit, last_bit, rd_addr,
        input  busy, done, rd_data, ovf
    );

    modport slave (
        input  start, abort, integration_time, first_bit, last_bit, rd_addr,
        output busy, done, rd_data, ovf
    );
endinterface

// File: rtl/instrumented_adder_sweep.sv
// Measurement sequencer for the instrumented adder: sweeps the ring-closing sum
// bit over [first_bit..last_bit], runs one timed edge-count window per bit and
// stores one count per bit in an internal result file read back over the bus.
// Optional feature macro: SWEEP_MAX_EN adds max_count_o / max_bit_o tracking.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a start with a valid bit range
// S_SETUP  | ring running on bit idx, synchronizer flushing, counter cleared
// S_COUNT  | integration window, rising edges of the ring tap counted
// S_STORE  | ring stopped, count written to result[idx]
// S_FINISH | one cycle before returning to idle; done rises afterwards
module instrumented_adder_sweep #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 32,
    parameter int TIME_W = 32,
    parameter int SETTLE = 4,
    localparam int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    instrumented_adder_sweep_if.slave   bus,
    input  logic                        ring_osc_in_i,
    output logic                        stop_b_o,
    output logic [WIDTH-1:0]            s_output_bit_b_o
`ifdef SWEEP_MAX_EN
    ,
    output logic [CNT_W-1:0]            max_count_o,
    output logic [AW-1:0]               max_bit_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_COUNT  = 3'd2,
        S_STORE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q;
    logic [AW-1:0]     last_q;
    logic [TIME_W-1:0] it_q;
    logic [TIME_W-1:0] timer_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0]  ovf_q;
    logic              done_q;
    logic [CNT_W-1:0]  result_q [WIDTH];
    logic [CNT_W-1:0]  rd_data_q;

    logic              range_ok;
    logic              start_ok;
    logic              abort_act;
    logic              store_wr;
    logic              edge_w;
    logic              cnt_full;
    logic [WIDTH-1:0]  sweep_mask;

    assign range_ok  = (bus.first_bit <= bus.last_bit) && (32'(bus.last_bit) < WIDTH);
    assign start_ok  = (state_q == S_IDLE) && bus.start && range_ok;
    assign abort_act = (state_q != S_IDLE) && bus.abort;
    // abort wins over the write in STORE
    assign store_wr  = (state_q == S_STORE) && !bus.abort;
    assign edge_w    = sync2_q & ~prev_q;
    assign cnt_full  = (cnt_q == {CNT_W{1'b1}});

    // Bits covered by the requested range; their ovf flags are cleared at start
    always_comb begin
        sweep_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sweep_mask[i] = (i >= int'(bus.first_bit)) && (i <= int'(bus.last_bit));
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort overrides every non-idle transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_SETUP;
            S_SETUP:  if (timer_q == '0) state_d = (it_q == '0) ? S_STORE : S_COUNT;
            S_COUNT:  if (timer_q == '0) state_d = S_STORE;
            S_STORE:  state_d = (idx_q == last_q) ? S_FINISH : S_SETUP;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_act) state_d = S_IDLE;
    end

    // Outputs decoded from state: ring enable, one-hot-low bit select, busy
    always_comb begin
        stop_b_o         = 1'b0;
        s_output_bit_b_o = '1;
        case (state_q)
            S_SETUP, S_COUNT: begin
                stop_b_o                = 1'b1;
                s_output_bit_b_o[idx_q] = 1'b0;
            end
            S_STORE: s_output_bit_b_o[idx_q] = 1'b0;
            default: ;
        endcase
    end

    // Window timer: down-counter loaded on entry to SETUP and COUNT, terminal count at 0
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= '0;
        end else if (state_d == S_SETUP && state_q != S_SETUP) begin
            timer_q <= TIME_W'(SETTLE - 1);
        end else if (state_q == S_SETUP && state_d == S_COUNT) begin
            timer_q <= it_q - 1'b1;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    // Sweep control: latch range and window length at start, step idx, report done
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx_q  <= '0;
            last_q <= '0;
            it_q   <= '0;
            done_q <= 1'b0;
        end else begin
            if (start_ok) begin
                idx_q  <= bus.first_bit;
                last_q <= bus.last_bit;
                it_q   <= bus.integration_time;
                done_q <= 1'b0;
            end else if (state_q == S_STORE && state_d == S_SETUP) begin
                idx_q  <= idx_q + 1'b1;
            end
            if (state_q == S_FINISH && !bus.abort) done_q <= 1'b1;
        end
    end

    // Ring tap synchronizer plus edge register; SETTLE >= 3 lets it refill in SETUP
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= ring_osc_in_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Saturating edge counter, cleared during SETUP
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (state_q == S_SETUP) begin
            cnt_q <= '0;
        end else if (state_q == S_COUNT && edge_w && !cnt_full) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Overflow flags: set when an edge is lost to saturation, cleared per swept bit at start
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovf_q <= '0;
        end else if (start_ok) begin
            ovf_q <= ovf_q & ~sweep_mask;
        end else if (state_q == S_COUNT && edge_w && cnt_full) begin
            ovf_q[idx_q] <= 1'b1;
        end
    end

    // Result file write
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < WIDTH; i++) result_q[i] <= '0;
        end else if (store_wr) begin
            result_q[idx_q] <= cnt_q;
        end
    end

    // Registered read port, independent of the FSM; a same-cycle write returns old data
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else if (32'(bus.rd_addr) < WIDTH) begin
            rd_data_q <= result_q[bus.rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

`ifdef SWEEP_MAX_EN
    logic [CNT_W-1:0] max_count_q;
    logic [AW-1:0]    max_bit_q;

    // Running maximum; strict compare keeps the lower bit on a tie
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            max_count_q <= '0;
            max_bit_q   <= '0;
        end else if (start_ok) begin
            max_count_q <= '0;
            max_bit_q   <= '0;
        end else if (store_wr && cnt_q > max_count_q) begin
            max_count_q <= cnt_q;
            max_bit_q   <= idx_q;
        end
    end

    assign max_count_o = max_count_q;
    assign max_bit_o   = max_bit_q;
`endif

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.rd_data = rd_data_q;

endmodule
